// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_stall_controller_pkg;

  localparam int unsigned DIV_CYCLES_DEFAULT = 32;
  localparam int unsigned REG_ADDR_W         = 5;
  localparam int unsigned STALL_CNT_W        = 32;

  // Divider sequencer states; encodings are fixed so debug dumps stay stable.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Stall/flush controls for the pipeline registers, one bundle per cycle.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_ma_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_ma_flush;
    logic ma_wb_flush;
  } pipe_ctrl_t;

  // True when a source operand that is actually read matches the producer.
  function automatic logic src_matches(input logic                  uses,
                                       input logic [REG_ADDR_W-1:0] rs,
                                       input logic [REG_ADDR_W-1:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side view of the hazard controller: stage status in, controls out.
interface hazard_stall_controller_if;

  logic [hazard_stall_controller_pkg::REG_ADDR_W-1:0]  ID_rs1;
  logic [hazard_stall_controller_pkg::REG_ADDR_W-1:0]  ID_rs2;
  logic                                                ID_uses_rs1;
  logic                                                ID_uses_rs2;
  logic                                                EX_valid;
  logic [hazard_stall_controller_pkg::REG_ADDR_W-1:0]  EX_rd;
  logic                                                EX_mem_read;
  logic                                                EX_regwrite_enable;
  logic                                                EX_is_div;
  logic                                                EX_branch_taken;
  logic                                                MA_mem_busy;

  logic                                                PC_stall;
  logic                                                IF_ID_stall;
  logic                                                ID_EX_stall;
  logic                                                EX_MA_stall;
  logic                                                IF_ID_flush;
  logic                                                ID_EX_flush;
  logic                                                EX_MA_flush;
  logic                                                MA_WB_flush;
  logic                                                DIV_start;
  logic                                                div_busy;
  logic [hazard_stall_controller_pkg::STALL_CNT_W-1:0] stall_count;

  // Pipeline side: reports stage contents, consumes controls.
  modport master (
    output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2,
    output EX_valid, EX_rd, EX_mem_read, EX_regwrite_enable,
    output EX_is_div, EX_branch_taken, MA_mem_busy,
    input  PC_stall, IF_ID_stall, ID_EX_stall, EX_MA_stall,
    input  IF_ID_flush, ID_EX_flush, EX_MA_flush, MA_WB_flush,
    input  DIV_start, div_busy, stall_count
  );

  // Controller side.
  modport slave (
    input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2,
    input  EX_valid, EX_rd, EX_mem_read, EX_regwrite_enable,
    input  EX_is_div, EX_branch_taken, MA_mem_busy,
    output PC_stall, IF_ID_stall, ID_EX_stall, EX_MA_stall,
    output IF_ID_flush, ID_EX_flush, EX_MA_flush, MA_WB_flush,
    output DIV_start, div_busy, stall_count
  );

endinterface

// File: rtl/hazard_stall_controller_div_sequencer.sv
// Multi-cycle divider sequencer: start pulse, busy window and EX hold request.
module div_sequencer
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ex_valid,
  input  logic ex_is_div,
  input  logic ma_mem_busy,
  output logic DIV_start,
  output logic div_busy,
  output logic div_hold
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_in_ex;

  assign div_in_ex = ex_valid && ex_is_div;

  // State and countdown registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter update and combinational outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    DIV_start = 1'b0;
    div_busy  = 1'b0;
    div_hold  = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_hold = div_in_ex;
        // A memory wait defers the launch; EX is frozen anyway.
        if (div_in_ex && !ma_mem_busy) begin
          DIV_start = 1'b1;
          cnt_d     = CNT_W'(DIV_CYCLES - 1);
          state_d   = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        div_busy = 1'b1;
        div_hold = 1'b1;
        // Counts through memory waits; the divider does not care about MA.
        if (cnt_q == '0) begin
          state_d = DIV_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DIV_DONE: begin
        // Leave only once EX really advances so the same DIV is not relaunched.
        if (!ma_mem_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (RESET) begin
      DIV_start = 1'b0;
      div_busy  = 1'b0;
      div_hold  = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller: prioritised stall/flush generation and stall statistics.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RESET,
  hazard_stall_controller_if.slave bus
);

  logic                   div_start;
  logic                   div_busy;
  logic                   div_hold;
  logic                   load_use;
  pipe_ctrl_t             ctrl;
  logic [STALL_CNT_W-1:0] stall_q;

  div_sequencer #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_sequencer (
    .CLK        (CLK),
    .RESET      (RESET),
    .ex_valid   (bus.EX_valid),
    .ex_is_div  (bus.EX_is_div),
    .ma_mem_busy(bus.MA_mem_busy),
    .DIV_start  (div_start),
    .div_busy   (div_busy),
    .div_hold   (div_hold)
  );

  // Load in EX whose result the ID instruction needs next cycle; x0 never hazards.
  assign load_use = bus.EX_valid && bus.EX_mem_read && bus.EX_regwrite_enable &&
                    (bus.EX_rd != '0) &&
                    (src_matches(bus.ID_uses_rs1, bus.ID_rs1, bus.EX_rd) ||
                     src_matches(bus.ID_uses_rs2, bus.ID_rs2, bus.EX_rd));

  // Highest-priority hazard alone decides the controls; reset silences all.
  always_comb begin
    ctrl = '0;
    if (RESET) begin
      ctrl = '0;
    end else if (bus.MA_mem_busy) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.if_id_stall = 1'b1;
      ctrl.id_ex_stall = 1'b1;
      ctrl.ex_ma_stall = 1'b1;
      ctrl.ma_wb_flush = 1'b1;
    end else if (div_hold) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.if_id_stall = 1'b1;
      ctrl.id_ex_stall = 1'b1;
      ctrl.ex_ma_flush = 1'b1;
    end else if (load_use) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.if_id_stall = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (bus.EX_valid && bus.EX_branch_taken) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end
  end

  // Saturating count of cycles in which fetch was held.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_q <= '0;
    end else if (ctrl.pc_stall && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign bus.PC_stall    = ctrl.pc_stall;
  assign bus.IF_ID_stall = ctrl.if_id_stall;
  assign bus.ID_EX_stall = ctrl.id_ex_stall;
  assign bus.EX_MA_stall = ctrl.ex_ma_stall;
  assign bus.IF_ID_flush = ctrl.if_id_flush;
  assign bus.ID_EX_flush = ctrl.id_ex_flush;
  assign bus.EX_MA_flush = ctrl.ex_ma_flush;
  assign bus.MA_WB_flush = ctrl.ma_wb_flush;
  assign bus.DIV_start   = div_start;
  assign bus.div_busy    = div_busy;
  assign bus.stall_count = RESET ? '0 : stall_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios plus random traffic.
module tb_hazard_stall_controller;

  localparam int DC = 32;

  // Bit positions in the packed observation vector.
  localparam int B_PC  = 9;
  localparam int B_IFS = 8;
  localparam int B_IDS = 7;
  localparam int B_EXS = 6;
  localparam int B_IFF = 5;
  localparam int B_IDF = 4;
  localparam int B_EXF = 3;
  localparam int B_MWF = 2;
  localparam int B_ST  = 1;
  localparam int B_BZ  = 0;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  hazard_stall_controller_if bus ();

  hazard_stall_controller #(.DIV_CYCLES(DC)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model: divider progress expressed as "cycle of the last launch".
  bit          m_started = 1'b0;
  int          m_t0      = 0;
  logic [31:0] m_cnt     = '0;

  logic [9:0]  last_vec;
  logic [31:0] last_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_vec();
    return {bus.PC_stall, bus.IF_ID_stall, bus.ID_EX_stall, bus.EX_MA_stall,
            bus.IF_ID_flush, bus.ID_EX_flush, bus.EX_MA_flush, bus.MA_WB_flush,
            bus.DIV_start, bus.div_busy};
  endfunction

  // Expected controls from the hazard rules and the divider's cycle window.
  function automatic logic [9:0] model_vec();
    logic [9:0] v;
    int  d;
    bit  in_busy, in_done, idle, div_ex, hold, lu, mb;
    v = '0;
    if (RESET) return v;
    d       = cyc - m_t0;
    in_busy = m_started && (d >= 1) && (d <= DC);
    in_done = m_started && (d > DC);
    idle    = !in_busy && !in_done;
    mb      = bus.MA_mem_busy;
    div_ex  = bus.EX_valid && bus.EX_is_div;
    hold    = (idle && div_ex) || in_busy;
    lu      = bus.EX_valid && bus.EX_mem_read && bus.EX_regwrite_enable && (bus.EX_rd != 5'd0) &&
              ((bus.ID_uses_rs1 && bus.ID_rs1 == bus.EX_rd) ||
               (bus.ID_uses_rs2 && bus.ID_rs2 == bus.EX_rd));
    v[B_ST] = idle && div_ex && !mb;
    v[B_BZ] = in_busy;
    if (mb) begin
      v[B_PC] = 1; v[B_IFS] = 1; v[B_IDS] = 1; v[B_EXS] = 1; v[B_MWF] = 1;
    end else if (hold) begin
      v[B_PC] = 1; v[B_IFS] = 1; v[B_IDS] = 1; v[B_EXF] = 1;
    end else if (lu) begin
      v[B_PC] = 1; v[B_IFS] = 1; v[B_IDF] = 1;
    end else if (bus.EX_valid && bus.EX_branch_taken) begin
      v[B_IFF] = 1; v[B_IDF] = 1;
    end
    return v;
  endfunction

  // One clock: check mid-cycle against the model, then advance the model at the edge.
  task automatic step(input string tag);
    logic [9:0] e;
    int d;
    @(negedge CLK);
    e        = model_vec();
    last_vec = obs_vec();
    last_cnt = bus.stall_count;
    check({tag, "_ctrl"}, 32'(last_vec), 32'(e));
    check({tag, "_cnt"}, last_cnt, RESET ? 32'd0 : m_cnt);
    @(posedge CLK);
    d = cyc - m_t0;
    if (RESET) begin
      m_started = 1'b0;
      m_cnt     = '0;
    end else begin
      if (e[B_ST]) begin
        m_started = 1'b1;
        m_t0      = cyc;
      end else if (m_started && (d > DC) && !bus.MA_mem_busy) begin
        m_started = 1'b0;
      end
      if (e[B_PC] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    cyc++;
    #1;
  endtask

  task automatic clear_in();
    bus.ID_rs1 = '0; bus.ID_rs2 = '0; bus.ID_uses_rs1 = 0; bus.ID_uses_rs2 = 0;
    bus.EX_valid = 0; bus.EX_rd = '0; bus.EX_mem_read = 0; bus.EX_regwrite_enable = 0;
    bus.EX_is_div = 0; bus.EX_branch_taken = 0; bus.MA_mem_busy = 0;
  endtask

  task automatic set_div();
    clear_in();
    bus.EX_valid = 1; bus.EX_is_div = 1; bus.EX_regwrite_enable = 1; bus.EX_rd = 5'd9;
  endtask

  initial begin
    logic [31:0] base;

    // Reset with a divide and a memory wait pending: everything quiet.
    clear_in();
    RESET = 1;
    bus.EX_valid = 1; bus.EX_is_div = 1; bus.MA_mem_busy = 1;
    #1;
    step("rst0");
    check("rst_outputs", 32'(last_vec), 32'd0);
    step("rst1");
    check("rst_count", last_cnt, 32'd0);

    RESET = 0;
    clear_in();
    step("idle");
    check("idle_count", last_cnt, 32'd0);
    check("idle_busy", 32'(last_vec[B_BZ]), 32'd0);

    // Load-use on x5: one bubble.
    bus.EX_valid = 1; bus.EX_mem_read = 1; bus.EX_regwrite_enable = 1; bus.EX_rd = 5'd5;
    bus.ID_uses_rs1 = 1; bus.ID_rs1 = 5'd5; bus.ID_uses_rs2 = 1; bus.ID_rs2 = 5'd6;
    step("lu_hit");
    check("lu_hit_vec", 32'(last_vec), 32'h300 | 32'h010);
    bus.EX_mem_read = 0; bus.EX_rd = 5'd5;
    step("lu_gone");
    check("lu_gone_pc", 32'(last_vec[B_PC]), 32'd0);
    // Same shape on x0: never a hazard.
    bus.EX_mem_read = 1; bus.EX_rd = 5'd0; bus.ID_rs1 = 5'd0;
    step("lu_x0");
    check("lu_x0_vec", 32'(last_vec), 32'd0);

    // Plain division, no memory waits.
    set_div();
    for (int k = 0; k <= DC + 1; k++) begin
      step("div");
      if (k == 0) base = last_cnt;
      check("div_start", 32'(last_vec[B_ST]), 32'(k == 0));
      check("div_exflush", 32'(last_vec[B_EXF]), 32'(k <= DC));
      check("div_busy", 32'(last_vec[B_BZ]), 32'(k >= 1 && k <= DC));
      if (k == DC + 1) check("div_done_nostall", 32'(last_vec[B_PC]), 32'd0);
    end
    clear_in();
    step("div_after");
    check("div_stall_total", last_cnt - base, 32'd33);

    // Division with memory waits inside the busy window and during the done state.
    set_div();
    for (int k = 0; k <= DC + 3; k++) begin
      bus.MA_mem_busy = (k >= 10 && k <= 12) || (k == DC + 1) || (k == DC + 2);
      step("divmw");
      check("divmw_start", 32'(last_vec[B_ST]), 32'(k == 0));
      check("divmw_busy", 32'(last_vec[B_BZ]), 32'(k >= 1 && k <= DC));
    end
    clear_in();
    step("divmw_after");
    check("divmw_after_start", 32'(last_vec[B_ST]), 32'd0);

    // Taken branch while memory is busy: held, then flushed when the wait ends.
    bus.EX_valid = 1; bus.EX_branch_taken = 1; bus.MA_mem_busy = 1;
    step("br_mb0");
    check("br_mb_flush", 32'(last_vec[B_IFF]), 32'd0);
    check("br_mb_exstall", 32'(last_vec[B_EXS]), 32'd1);
    step("br_mb1");
    bus.MA_mem_busy = 0;
    step("br_go");
    check("br_go_vec", 32'(last_vec), 32'h030);
    clear_in();

    // Reset in the middle of a division, then a fresh launch.
    set_div();
    for (int k = 0; k <= 7; k++) begin
      RESET = (k == 5);
      if (k == 6) clear_in();
      if (k == 7) set_div();
      step("divrst");
      if (k == 6) check("divrst_busy", 32'(last_vec[B_BZ]), 32'd0);
      if (k == 7) check("divrst_restart", 32'(last_vec[B_ST]), 32'd1);
    end
    clear_in();
    for (int k = 0; k < DC + 2; k++) step("divrst_drain");

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      RESET                  = ($urandom_range(0, 79) == 0);
      bus.ID_rs1             = 5'($urandom_range(0, 3));
      bus.ID_rs2             = 5'($urandom_range(0, 3));
      bus.ID_uses_rs1        = 1'($urandom);
      bus.ID_uses_rs2        = 1'($urandom);
      bus.EX_valid           = ($urandom_range(0, 3) != 0);
      bus.EX_rd              = 5'($urandom_range(0, 3));
      bus.EX_mem_read        = 1'($urandom);
      bus.EX_regwrite_enable = 1'($urandom);
      bus.EX_is_div          = ($urandom_range(0, 11) == 0);
      bus.EX_branch_taken    = ($urandom_range(0, 3) == 0);
      bus.MA_mem_busy        = ($urandom_range(0, 4) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
